instr_prefetch_queue: RTL and testbench

- Parametrised successor to the single-word instruction register.
- Buffers up to DEPTH fetched instruction words in a circular FIFO, filled by the fetch side through a valid/ready handshake.
- Presents the oldest word in an output instruction register when the control unit asserts ir_load.
- Supports a synchronous flush for branches and jumps, and reports occupancy status.

---
 rtl/instr_pkg.sv | 15 +
 rtl/instr_prefetch_queue_if.sv | 33 +++
 rtl/instr_queue_mem.sv | 28 ++
 rtl/instr_prefetch_queue.sv | 87 ++++++++
 tb/tb_instr_prefetch_queue.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/instr_pkg.sv
// Shared constants and helpers for the instruction prefetch queue slice.
package instr_pkg;

    localparam int DEFAULT_WORD_SIZE = 8;
    localparam int DEFAULT_DEPTH     = 4;

    // Opcode that a bubble is expected to look like downstream
    localparam logic [7:0] NOP_OPCODE = 8'h00;

    // Occupancy counter width: must be able to represent 0..depth inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Fetch/control-side bundle of the prefetch queue: handshake in, IR and status out.
import instr_pkg::*;

interface instr_prefetch_queue_if #(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int DEPTH     = DEFAULT_DEPTH
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic                 flush;
    logic                 in_valid;
    logic [WORD_SIZE-1:0] in_data;
    logic                 in_ready;
    logic                 ir_load;
    logic [WORD_SIZE-1:0] ir_out;
    logic                 ir_valid;
    logic [CNT_W-1:0]     count;
    logic                 empty;
    logic                 full;

    // Fetch unit and control unit side
    modport master (
        output flush, in_valid, in_data, ir_load,
        input  in_ready, ir_out, ir_valid, count, empty, full
    );

    // Queue side
    modport slave (
        input  flush, in_valid, in_data, ir_load,
        output in_ready, ir_out, ir_valid, count, empty, full
    );

endinterface

// File: rtl/instr_queue_mem.sv
// Storage for queued instruction words: one write port, one asynchronous read port, no reset.
import instr_pkg::*;

module instr_queue_mem #(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int PTR_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [PTR_W-1:0]     waddr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [PTR_W-1:0]     raddr,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] mem [DEPTH];

    // Capture the incoming word into the addressed slot on an accepted write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Circular prefetch queue feeding an instruction register, with flush and occupancy status.
import instr_pkg::*;

module instr_prefetch_queue #(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int DEPTH     = DEFAULT_DEPTH
) (
    input logic                    clk,
    input logic                    rst,
    instr_prefetch_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count_q;
    logic [WORD_SIZE-1:0] ir_q;
    logic                 ir_valid_q;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 empty_w;
    logic                 full_w;
    logic                 wr_en;
    logic                 rd_en;

    // Status comes from the counter alone, so pointer equality never needs disambiguating
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CNT_W'(DEPTH));

    // Flush wins over both ports; a read needs a queued word, never the one being written
    assign bus.in_ready = !full_w && !bus.flush;
    assign wr_en        = bus.in_valid && bus.in_ready;
    assign rd_en        = bus.ir_load && !empty_w && !bus.flush;

    assign bus.empty    = empty_w;
    assign bus.full     = full_w;
    assign bus.count    = count_q;
    assign bus.ir_out   = ir_q;
    assign bus.ir_valid = ir_valid_q;

    instr_queue_mem #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH),
        .PTR_W     (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Pointers, occupancy and instruction register; flush discards the queue but keeps the IR word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr     <= rd_ptr + 1'b1;
                ir_q       <= rd_data;
                ir_valid_q <= 1'b1;
            end else if (bus.ir_load) begin
                ir_valid_q <= 1'b0;
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomized and directed self-checking bench for instr_prefetch_queue against a queue-based model.
import instr_pkg::*;

module tb_instr_prefetch_queue;

    localparam int WS    = DEFAULT_WORD_SIZE;
    localparam int DEPTH = DEFAULT_DEPTH;

    logic clk;
    logic rst;

    instr_prefetch_queue_if #(.WORD_SIZE(WS), .DEPTH(DEPTH)) bus ();

    instr_prefetch_queue #(.WORD_SIZE(WS), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: the queue contents as a list, plus the IR word and its valid flag
    logic [WS-1:0] model_q[$];
    logic [WS-1:0] model_ir;
    logic          model_valid;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        model_ir    = '0;
        model_valid = 1'b0;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".ir_out"},   32'(bus.ir_out),   32'(model_ir));
        checkOutput({tag, ".ir_valid"}, 32'(bus.ir_valid), 32'(model_valid));
        checkOutput({tag, ".count"},    32'(bus.count),    32'(model_q.size()));
        checkOutput({tag, ".empty"},    32'(bus.empty),    32'(model_q.size() == 0));
        checkOutput({tag, ".full"},     32'(bus.full),     32'(model_q.size() == DEPTH));
    endtask

    // Drive one cycle of inputs, check in_ready before the edge, advance the model, then check state
    task automatic applyStimulus(input logic valid, input logic [WS-1:0] data,
                                 input logic load, input logic fl, input string tag);
        bit accept;
        bit pop;
        bus.in_valid = valid;
        bus.in_data  = data;
        bus.ir_load  = load;
        bus.flush    = fl;
        #1;
        checkOutput({tag, ".in_ready"}, 32'(bus.in_ready), 32'((model_q.size() < DEPTH) && !fl));
        @(posedge clk);
        if (fl) begin
            model_q.delete();
            model_valid = 1'b0;
        end else begin
            accept = valid && (model_q.size() < DEPTH);
            pop    = load && (model_q.size() > 0);
            if (pop) begin
                model_ir    = model_q.pop_front();
                model_valid = 1'b1;
            end else if (load) begin
                model_valid = 1'b0;
            end
            if (accept) model_q.push_back(data);
        end
        #1;
        checkState(tag);
    endtask

    // Pull reset low between edges and confirm the outputs clear without any clock edge
    task automatic asyncReset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkState(tag);
        #1;
        rst = 1'b1;
        #1;
        checkOutput({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.ir_load  = 1'b0;
        bus.flush    = 1'b0;
        modelReset();

        // Reset then idle
        #2;
        rst = 1'b0;
        #1;
        checkState("reset");
        #4;
        rst = 1'b1;
        #1;
        checkOutput("reset.in_ready", 32'(bus.in_ready), 32'd1);

        // Fill to full, then offer a fifth word that must be refused
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0, "fill1");
        applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0, "fill2");
        applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0, "fill3");
        applyStimulus(1'b1, 8'hA4, 1'b0, 1'b0, "fill4");
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, "fill5");

        // Drain in order, the last load being a bubble
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        checkOutput("drain.bubble_ir", 32'(bus.ir_out), 32'hA4);

        // Concurrent read and write at count 2 with pointer wrap
        applyStimulus(1'b1, 8'h0E, 1'b0, 1'b0, "pre1");
        applyStimulus(1'b1, 8'h0F, 1'b0, 1'b0, "pre2");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b1, 1'b0, "concur");
            checkOutput("concur.seq", 32'(bus.ir_out), 32'(8'h0E + i));
        end

        // Flush priority at count 3 with a valid IR word
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, "pre3");
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1, "flush");
        checkOutput("flush.ir_hold", 32'(bus.ir_out), 32'h17);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, "post_w");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "post_r");
        checkOutput("flush.next", 32'(bus.ir_out), 32'h55);

        // Asynchronous reset with words queued, then a bubble on the first load
        applyStimulus(1'b1, 8'h61, 1'b0, 1'b0, "ar_w1");
        applyStimulus(1'b1, 8'h62, 1'b0, 1'b0, "ar_w2");
        asyncReset("areset");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "ar_load");
        checkOutput("areset.bubble", 32'(bus.ir_out), 32'(NOP_OPCODE));

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
